// File: rtl/version_pkg.sv
// Shared types and defaults for the build-identity block.
package version_pkg;

  localparam int MAJOR_W_DEF  = 4;
  localparam int MINOR_W_DEF  = 6;
  localparam int PATCH_W_DEF  = 6;
  localparam int BUILD_W_DEF  = 8;
  localparam int COMMIT_W_DEF = 40;
  localparam int ADDR_W_DEF   = 3;

  typedef logic [31:0] word_t;

  // Serial dump engine states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Number of 32-bit words needed to hold {version, commit}.
  function automatic int n_words(input int ver_w, input int commit_w);
    return (ver_w + commit_w + 31) / 32;
  endfunction

endpackage

// File: rtl/version_ser.sv
// Bit-serial dump of the identity image, MSB first, one bit per cycle.
module version_ser
  import version_pkg::*;
#(
  parameter int               IMG_W = 64,
  parameter logic [IMG_W-1:0] IMG   = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dump_start,
  output logic       ser_valid,
  output logic       ser_data,
  output logic       ser_last,
  output ser_state_t state_dbg
);

  localparam int CNT_W = $clog2(IMG_W);

  ser_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  assign state_dbg = state;

  // State and bit counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and outputs; start pulses outside IDLE are ignored, and the
  // counter stops at 0 rather than wrapping.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_start) begin
          state_nx = ST_SHIFT;
          cnt_nx   = CNT_W'(IMG_W - 1);
        end
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = IMG[cnt];
        if (cnt == '0) begin
          ser_last = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/version_regs.sv
// Build identity: static outputs, one-deep word-read port, serial dump.
module version_regs
  import version_pkg::*;
#(
  parameter int          MAJOR_W       = MAJOR_W_DEF,
  parameter int          MINOR_W       = MINOR_W_DEF,
  parameter int          PATCH_W       = PATCH_W_DEF,
  parameter int          BUILD_W       = BUILD_W_DEF,
  parameter int          COMMIT_W      = COMMIT_W_DEF,
  parameter logic [31:0] VERSION_MAJOR = 32'd0,
  parameter logic [31:0] VERSION_MINOR = 32'd0,
  parameter logic [31:0] VERSION_PATCH = 32'd0,
  parameter logic [31:0] VERSION_BUILD = 32'd0,
  parameter logic [COMMIT_W-1:0] COMMIT = '0,
  parameter int          ADDR_W        = ADDR_W_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  output logic [MAJOR_W+MINOR_W+PATCH_W+BUILD_W-1:0] version_out,
  output logic [COMMIT_W-1:0]                        commit_out,
  input  logic                                       rd_req_valid,
  output logic                                       rd_req_ready,
  input  logic [ADDR_W-1:0]                          rd_addr,
  output logic                                       rd_rsp_valid,
  input  logic                                       rd_rsp_ready,
  output logic [31:0]                                rd_rsp_data,
  output logic                                       rd_rsp_err,
  input  logic                                       dump_start,
  output logic                                       dump_busy,
  output logic                                       ser_valid,
  output logic                                       ser_data,
  output logic                                       ser_last
);

  localparam int VER_W   = MAJOR_W + MINOR_W + PATCH_W + BUILD_W;
  localparam int N_WORDS = n_words(VER_W, COMMIT_W);
  localparam int IMG_W   = N_WORDS * 32;

  localparam logic [VER_W-1:0] VERSION = {VERSION_MAJOR[MAJOR_W-1:0],
                                          VERSION_MINOR[MINOR_W-1:0],
                                          VERSION_PATCH[PATCH_W-1:0],
                                          VERSION_BUILD[BUILD_W-1:0]};
  localparam logic [VER_W+COMMIT_W-1:0] PACKED = {VERSION, COMMIT};
  // Zero-padded on the top to a whole number of words.
  localparam logic [IMG_W-1:0] IMG = IMG_W'(PACKED);

  assign version_out = VERSION;
  assign commit_out  = COMMIT;

  // Word table covering the whole address space; out-of-range slots read 0.
  word_t img_words [2**ADDR_W];
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_words
    if (i < N_WORDS) begin : g_real
      assign img_words[i] = IMG[32*i +: 32];
    end else begin : g_pad
      assign img_words[i] = '0;
    end
  end

  // Handshake: a request transfers on a cycle where rd_req_valid && rd_req_ready;
  // a response transfers where rd_rsp_valid && rd_rsp_ready. The single response
  // slot can take a new request whenever it is empty or being drained this cycle,
  // and an unconsumed response holds its data unchanged.
  logic rd_accept;
  logic addr_bad;

  assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign addr_bad     = !(32'(rd_addr) < N_WORDS);

  // Response slot: load on acceptance, empty once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_err   <= 1'b0;
    end else if (rd_accept) begin
      rd_rsp_valid <= 1'b1;
      rd_rsp_data  <= img_words[rd_addr];
      rd_rsp_err   <= addr_bad;
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
  end

  ser_state_t ser_state;

  version_ser #(
    .IMG_W(IMG_W),
    .IMG  (IMG)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_start(dump_start),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_last  (ser_last),
    .state_dbg (ser_state)
  );

  assign dump_busy = (ser_state == ST_SHIFT);

endmodule

// File: tb/tb_version_regs.sv
// Self-checking bench for version_regs with default widths.
module tb_version_regs;

  // Reference image built from the field values: {pad, major, minor, patch, build, commit}.
  localparam int          IMG_BITS = 64;
  localparam logic [63:0] IMG_M = (64'd1 << 60) | (64'd2 << 54) | (64'd3 << 48) |
                                  (64'd4 << 40) | 64'hAB_1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] version_out;
  logic [39:0] commit_out;
  logic        rd_req_valid = 1'b0;
  logic        rd_req_ready;
  logic [2:0]  rd_addr = '0;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready = 1'b1;
  logic [31:0] rd_rsp_data;
  logic        rd_rsp_err;
  logic        dump_start = 1'b0;
  logic        dump_busy;
  logic        ser_valid;
  logic        ser_data;
  logic        ser_last;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  version_regs #(
    .VERSION_MAJOR(32'd1),
    .VERSION_MINOR(32'd2),
    .VERSION_PATCH(32'd3),
    .VERSION_BUILD(32'd4),
    .COMMIT       (40'hAB_1234_5678)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .version_out (version_out),
    .commit_out  (commit_out),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_addr     (rd_addr),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data (rd_rsp_data),
    .rd_rsp_err  (rd_rsp_err),
    .dump_start  (dump_start),
    .dump_busy   (dump_busy),
    .ser_valid   (ser_valid),
    .ser_data    (ser_data),
    .ser_last    (ser_last)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected {err, data} for a word read.
  function automatic logic [32:0] exp_word(input logic [2:0] a);
    logic [63:0] img;
    img = IMG_M;
    if (int'(a) < 2) return {1'b0, img[32*int'(a) +: 32]};
    return {1'b1, 32'h0};
  endfunction

  function automatic logic img_bit(input int i);
    logic [63:0] img;
    img = IMG_M;
    return img[i];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; dump_start = 1'b1; rd_req_valid = 1'b1; rd_addr = 3'd0; rd_rsp_ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({rd_rsp_valid, rd_rsp_data, rd_rsp_err, dump_busy, ser_valid, ser_data, ser_last} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b data=%h err=%b busy=%b sv=%b sd=%b sl=%b want all 0",
               rd_rsp_valid, rd_rsp_data, rd_rsp_err, dump_busy, ser_valid, ser_data, ser_last);
    end
    rst_n = 1'b1; dump_start = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    tick();
    total++;
    if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", rd_req_ready); end
    total++;
    if (dump_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", dump_busy); end
    total++;
    if (version_out !== 24'h10_8304) begin bad++; $display("FAIL version_out got %h want 108304", version_out); end
    total++;
    if (commit_out !== 40'hAB_1234_5678) begin bad++; $display("FAIL commit_out got %h want ab12345678", commit_out); end
  endtask

  task automatic test_read_basic();
    logic [2:0]  addrs [4] = '{3'd0, 3'd1, 3'd5, 3'd0};
    logic [32:0] wants [4] = '{{1'b0, 32'h1234_5678}, {1'b0, 32'h1083_04AB},
                               {1'b1, 32'h0}, {1'b0, 32'h1234_5678}};
    rd_rsp_ready = 1'b1;
    rd_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = addrs[i];
      #1;
      total++;
      if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, rd_req_ready); end
      tick();
      total++;
      if ({rd_rsp_valid, rd_rsp_err, rd_rsp_data} !== {1'b1, wants[i]}) begin
        bad++;
        $display("FAIL read_basic[%0d] addr=%0d got v=%b err=%b data=%h want v=1 err=%b data=%h",
                 i, addrs[i], rd_rsp_valid, rd_rsp_err, rd_rsp_data, wants[i][32], wants[i][31:0]);
      end
    end
    rd_req_valid = 1'b0;
    tick();
    total++;
    if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL read_drain got v=%b want 0", rd_rsp_valid); end
  endtask

  task automatic test_stall();
    rd_req_valid = 1'b1; rd_addr = 3'd1; rd_rsp_ready = 1'b1;
    tick();
    rd_addr = 3'd0; rd_rsp_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({rd_rsp_valid, rd_rsp_err, rd_rsp_data} !== {2'b10, 32'h1083_04AB}) begin
        bad++;
        $display("FAIL stall_hold[%0d] got v=%b err=%b data=%h want v=1 err=0 data=108304ab",
                 c, rd_rsp_valid, rd_rsp_err, rd_rsp_data);
      end
      total++;
      if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got %b want 0", c, rd_req_ready); end
      tick();
    end
    rd_rsp_ready = 1'b1;
    #1;
    total++;
    if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got %b want 1", rd_req_ready); end
    tick();
    total++;
    if ({rd_rsp_valid, rd_rsp_err, rd_rsp_data} !== {2'b10, 32'h1234_5678}) begin
      bad++;
      $display("FAIL stall_second got v=%b err=%b data=%h want v=1 err=0 data=12345678",
               rd_rsp_valid, rd_rsp_err, rd_rsp_data);
    end
    rd_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_read_random();
    logic       v, r, exp_ready;
    logic [2:0] a;
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      a = 3'($urandom_range(0, 7));
      rd_req_valid = v; rd_addr = a; rd_rsp_ready = r;
      #1;
      total++;
      if (rd_rsp_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rand_valid[%0d] got %b want %b", c, rd_rsp_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        total++;
        if ({rd_rsp_err, rd_rsp_data} !== exp_q[0]) begin
          bad++;
          $display("FAIL rand_data[%0d] got err=%b data=%h want err=%b data=%h",
                   c, rd_rsp_err, rd_rsp_data, exp_q[0][32], exp_q[0][31:0]);
        end
      end
      exp_ready = (exp_q.size() == 0) || r;
      total++;
      if (rd_req_ready !== exp_ready) begin
        bad++; $display("FAIL rand_ready[%0d] got %b want %b", c, rd_req_ready, exp_ready);
      end
      if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
      if (v && exp_ready) exp_q.push_back(exp_word(a));
      tick();
    end
    rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_dump(input bit repulse);
    int nbits = 0;
    bit seen_end = 1'b0;
    total++;
    if (dump_busy !== 1'b0) begin bad++; $display("FAIL dump_idle_before got busy=%b want 0", dump_busy); end
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    total++;
    if (ser_valid !== 1'b1) begin bad++; $display("FAIL dump_first_bit got ser_valid=%b want 1", ser_valid); end
    for (int c = 0; c < 80; c++) begin
      if (ser_valid === 1'b1) begin
        if (seen_end) begin
          total++; bad++;
          $display("FAIL dump_gap at cycle %0d got ser_valid=1 want 0 after end", c);
        end
        if (nbits < IMG_BITS) begin
          total++;
          if (ser_data !== img_bit(IMG_BITS - 1 - nbits)) begin
            bad++; $display("FAIL dump_bit[%0d] got %b want %b", nbits, ser_data, img_bit(IMG_BITS - 1 - nbits));
          end
          total++;
          if (ser_last !== (nbits == IMG_BITS - 1)) begin
            bad++; $display("FAIL dump_last[%0d] got %b want %b", nbits, ser_last, nbits == IMG_BITS - 1);
          end
          total++;
          if (dump_busy !== 1'b1) begin bad++; $display("FAIL dump_busy[%0d] got %b want 1", nbits, dump_busy); end
        end
        nbits++;
        dump_start = repulse && (nbits == 11 || nbits == IMG_BITS);
      end else begin
        seen_end = 1'b1;
        dump_start = 1'b0;
        total++;
        if (dump_busy !== 1'b0 || ser_last !== 1'b0) begin
          bad++; $display("FAIL dump_after[%0d] got busy=%b last=%b want 0 0", c, dump_busy, ser_last);
        end
      end
      tick();
    end
    dump_start = 1'b0;
    total++;
    if (nbits != IMG_BITS) begin bad++; $display("FAIL dump_count got %0d want %0d", nbits, IMG_BITS); end
  endtask

  task automatic test_reset_mid();
    rd_req_valid = 1'b1; rd_addr = 3'd1; rd_rsp_ready = 1'b1;
    tick();
    rd_req_valid = 1'b0; rd_rsp_ready = 1'b0; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (20) tick();
    total++;
    if (ser_valid !== 1'b1 || rd_rsp_valid !== 1'b1 || ser_data !== img_bit(IMG_BITS - 21)) begin
      bad++;
      $display("FAIL mid_setup got sv=%b rv=%b sd=%b want 1 1 %b", ser_valid, rd_rsp_valid, ser_data,
               img_bit(IMG_BITS - 21));
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({rd_rsp_valid, rd_rsp_data, rd_rsp_err, dump_busy, ser_valid, ser_data, ser_last} !== 38'd0) begin
      bad++;
      $display("FAIL mid_reset got valid=%b data=%h err=%b busy=%b sv=%b sd=%b sl=%b want all 0",
               rd_rsp_valid, rd_rsp_data, rd_rsp_err, dump_busy, ser_valid, ser_data, ser_last);
    end
    rst_n = 1'b1; rd_rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (ser_valid !== 1'b0 || rd_rsp_valid !== 1'b0 || dump_busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_after[%0d] got sv=%b rv=%b busy=%b want 0 0 0", c, ser_valid, rd_rsp_valid, dump_busy);
      end
    end
    test_dump(1'b0);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_stall();
    test_read_random();
    test_dump(1'b0);
    test_dump(1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
